// File: rtl/reel_pkg.sv
// Shared types for the reel spinner: global FSM states, per-reel modes and
// the control bundle the top broadcasts to every reel.
package reel_pkg;

  typedef enum logic [1:0] {IDLE, SPIN, STOPPING} state_t;

  typedef enum logic [1:0] {HOLD, ACCEL, DECEL} mode_t;

  // load: restart the reel from its base period; mode: how the period ramps
  typedef struct packed {
    logic  load;
    mode_t mode;
  } reel_ctrl_t;

endpackage

// File: rtl/reel_unit.sv
// One reel: tick counter, ramping advance period, wrapping digit, halt flag.
// halting/digit_nxt expose this cycle's outcome so the top can finish and
// score the game on the same edge as the last halting advance.
module reel_unit
  import reel_pkg::*;
#(
  parameter int DIGIT_W    = 4,
  parameter int MODULUS    = 10,
  parameter int PERIOD_W   = 32,
  parameter int BASE       = 250000,
  parameter int RAMP_STEP  = 1000,
  parameter int MIN_PERIOD = 100000,
  parameter int MAX_PERIOD = 400000
) (
  input  logic               clk,
  input  logic               rst,
  input  reel_ctrl_t         ctrl,
  output logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] digit_nxt,
  output logic               stopped,
  output logic               halting
);

  localparam logic [PERIOD_W-1:0] BASE_P = PERIOD_W'(BASE);
  // One extra bit so the ramp sums cannot wrap
  localparam logic [PERIOD_W:0]   RAMP_W = (PERIOD_W+1)'(RAMP_STEP);
  localparam logic [PERIOD_W:0]   MIN_W  = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   MAX_W  = (PERIOD_W+1)'(MAX_PERIOD);

  logic [PERIOD_W-1:0] tick, cur_period, period_dn;
  logic [PERIOD_W:0]   period_up;
  logic                running, adv;

  // Advance detection, saturating period ramps, next digit value
  always_comb begin
    running   = !stopped && (ctrl.mode != HOLD);
    adv       = running && (tick == cur_period - PERIOD_W'(1));
    period_up = {1'b0, cur_period} + RAMP_W;
    period_dn = ({1'b0, cur_period} >= MIN_W + RAMP_W) ?
                cur_period - RAMP_W[PERIOD_W-1:0] : MIN_W[PERIOD_W-1:0];
    halting   = adv && (ctrl.mode == DECEL) && (period_up > MAX_W);
    digit_nxt = digit;
    if (adv)
      digit_nxt = (int'(digit) == MODULUS - 1) ? '0 : digit + DIGIT_W'(1);
  end

  // Reel state: reload on start, otherwise count and advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick       <= '0;
      cur_period <= BASE_P;
      digit      <= '0;
      stopped    <= 1'b1;
    end else if (ctrl.load) begin
      tick       <= '0;
      cur_period <= BASE_P;
      stopped    <= 1'b0;
    end else if (adv) begin
      tick  <= '0;
      digit <= digit_nxt;
      if (ctrl.mode == ACCEL) cur_period <= period_dn;
      else if (halting)       stopped    <= 1'b1;
      else                    cur_period <= period_up[PERIOD_W-1:0];
    end else if (running) begin
      tick <= tick + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/reel_spinner.sv
// Multi-reel digit spinner: global IDLE/SPIN/STOPPING FSM, start/stop
// qualification, and the done pulse / win flag on final halt.
module reel_spinner
  import reel_pkg::*;
#(
  parameter int NUM_REELS   = 3,
  parameter int DIGIT_W     = 4,
  parameter int MODULUS     = 10,
  parameter int PERIOD_W    = 32,
  parameter int BASE_PERIOD = 250000,
  parameter int PERIOD_STEP = 50000,
  parameter int RAMP_STEP   = 1000,
  parameter int MIN_PERIOD  = 100000,
  parameter int MAX_PERIOD  = 400000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  output logic [NUM_REELS*DIGIT_W-1:0] digits,
  output logic [NUM_REELS-1:0]         stopped,
  output logic                         busy,
  output logic                         done,
  output logic                         win
);

  state_t                            state, state_nxt;
  reel_ctrl_t                        ctrl;
  logic [NUM_REELS-1:0][DIGIT_W-1:0] dig, dig_nxt;
  logic [NUM_REELS-1:0]              halting;
  logic                              start_acc, finish, all_eq;

  // Next state; the game finishes when every reel is halted or halting now
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (start) begin
        start_acc = 1'b1;
        state_nxt = SPIN;
      end
      SPIN: if (stop) state_nxt = STOPPING;
      STOPPING: if (&(stopped | halting)) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Broadcast control: reload on accepted start, ramp direction from state
  always_comb begin
    ctrl.load = start_acc;
    case (state)
      SPIN:     ctrl.mode = ACCEL;
      STOPPING: ctrl.mode = DECEL;
      default:  ctrl.mode = HOLD;
    endcase
  end

  // Score on the landing digits (post-advance values)
  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < NUM_REELS; i++)
      if (dig_nxt[i] != dig_nxt[0]) all_eq = 1'b0;
  end

  // Global state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // done pulse and win flag, both registered on the finishing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      win  <= 1'b0;
    end else begin
      done <= finish;
      if (start_acc)   win <= 1'b0;
      else if (finish) win <= all_eq;
    end
  end

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    reel_unit #(
      .DIGIT_W   (DIGIT_W),
      .MODULUS   (MODULUS),
      .PERIOD_W  (PERIOD_W),
      .BASE      (BASE_PERIOD - g * PERIOD_STEP),
      .RAMP_STEP (RAMP_STEP),
      .MIN_PERIOD(MIN_PERIOD),
      .MAX_PERIOD(MAX_PERIOD)
    ) u_reel (
      .clk      (clk),
      .rst      (rst),
      .ctrl     (ctrl),
      .digit    (dig[g]),
      .digit_nxt(dig_nxt[g]),
      .stopped  (stopped[g]),
      .halting  (halting[g])
    );
  end

  assign digits = dig;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_reel_spinner.sv
// Randomized bench for reel_spinner against a countdown-based reference
// model, plus fixed first-advance / period-ramp timing checks.
module tb_reel_spinner;

  localparam int NR = 3, DW = 4, MOD = 10;
  localparam int BASE = 20, STEP = 4, RAMP = 2, MINP = 8, MAXP = 30;
  localparam int P_IDLE = 0, P_SPIN = 1, P_STOP = 2;

  logic              clk = 1'b0, rst, start, stop;
  logic [NR*DW-1:0]  digits;
  logic [NR-1:0]     stopped;
  logic              busy, done, win;

  int n_chk = 0, n_err = 0, cyc = 0;

  // reference model: time-to-next-advance per reel, plain integers
  int m_dig[NR], m_per[NR], m_left[NR];
  bit m_halt[NR];
  int m_phase;
  bit m_done, m_win;

  // timing trace of the DUT's digit changes after a start
  bit trace = 0;
  int t_start;
  int first_adv[NR];
  int adv2[4];
  int n2;
  logic [DW-1:0] prev[NR];

  reel_spinner #(
    .NUM_REELS(NR), .DIGIT_W(DW), .MODULUS(MOD), .PERIOD_W(32),
    .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .RAMP_STEP(RAMP),
    .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .digits(digits),
    .stopped(stopped), .busy(busy), .done(done), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_dig[r] = 0; m_per[r] = 0; m_left[r] = 0; m_halt[r] = 1'b1;
    end
    m_phase = P_IDLE; m_done = 1'b0; m_win = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit p);
    bit all_h;
    m_done = 1'b0;
    if (m_phase == P_IDLE) begin
      if (s) begin
        for (int r = 0; r < NR; r++) begin
          m_per[r] = BASE - r * STEP; m_left[r] = m_per[r]; m_halt[r] = 1'b0;
        end
        m_win = 1'b0; m_phase = P_SPIN;
      end
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (!m_halt[r]) begin
          m_left[r]--;
          if (m_left[r] == 0) begin
            m_dig[r] = (m_dig[r] + 1) % MOD;
            if (m_phase == P_SPIN)           m_per[r] = (m_per[r] - RAMP < MINP) ? MINP : m_per[r] - RAMP;
            else if (m_per[r] + RAMP > MAXP) m_halt[r] = 1'b1;
            else                             m_per[r] = m_per[r] + RAMP;
            m_left[r] = m_per[r];
          end
        end
      end
      if (m_phase == P_STOP) begin
        all_h = 1'b1;
        for (int r = 0; r < NR; r++) all_h &= m_halt[r];
        if (all_h) begin
          m_phase = P_IDLE; m_done = 1'b1;
          m_win = (m_dig[0] == m_dig[1]) && (m_dig[1] == m_dig[2]);
        end
      end else if (p) begin
        m_phase = P_STOP;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] ed, es;
    ed = 0; es = 0;
    for (int r = 0; r < NR; r++) begin
      ed[r*DW +: DW] = DW'(m_dig[r]);
      es[r] = m_halt[r];
    end
    chk("digits",  32'(digits),  ed);
    chk("stopped", 32'(stopped), es);
    chk("busy",    32'(busy),    32'(m_phase != P_IDLE));
    chk("done",    32'(done),    32'(m_done));
    chk("win",     32'(win),     32'(m_win));
  endtask

  function automatic bit noise();
    return $urandom_range(0, 15) == 0;
  endfunction

  // one clock: drive inputs, step model on the edge, compare 1 time unit later
  task automatic cycle(input bit s, input bit p);
    start = s; stop = p;
    @(posedge clk);
    cyc++;
    model_step(s, p);
    #1;
    check_all();
    if (trace) begin
      for (int r = 0; r < NR; r++) begin
        if (digits[r*DW +: DW] != prev[r]) begin
          if (first_adv[r] < 0) first_adv[r] = cyc - t_start;
          if (r == 2 && n2 < 4) begin adv2[n2] = cyc - t_start; n2++; end
        end
        prev[r] = digits[r*DW +: DW];
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  // start from IDLE and verify staggered first advances and reel 2 ramp
  task automatic traced_start(input bit with_stop);
    for (int r = 0; r < NR; r++) begin
      first_adv[r] = -1; prev[r] = digits[r*DW +: DW];
    end
    n2 = 0; adv2 = '{-1, -1, -1, -1};
    t_start = cyc + 1; trace = 1'b1;
    cycle(1'b1, with_stop);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("stopped_cleared", 32'(stopped), 32'd0);
    repeat (59) cycle(noise(), 1'b0);
    trace = 1'b0;
    chk("first_adv_r0", first_adv[0], 32'd20);
    chk("first_adv_r1", first_adv[1], 32'd16);
    chk("first_adv_r2", first_adv[2], 32'd12);
    chk("r2_period0", adv2[0],           32'd12);
    chk("r2_period1", adv2[1] - adv2[0], 32'd10);
    chk("r2_period2", adv2[2] - adv2[1], 32'd8);
    chk("r2_period3", adv2[3] - adv2[2], 32'd8);
  endtask

  task automatic run_until_idle();
    int n = 0;
    while (m_phase != P_IDLE && n < 3000) begin
      cycle(noise(), noise());
      n++;
    end
    chk("stop_budget", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_stopped", 32'(stopped), 32'b111);
    chk("rst_digits",  32'(digits),  32'd0);
    rst = 1'b0;

    // stop in IDLE does nothing
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    for (int rnd = 0; rnd < 4; rnd++) begin
      repeat ($urandom_range(1, 6)) cycle(1'b0, noise());
      // round 1 issues start and stop together: stop must be dropped
      traced_start(rnd == 1);
      repeat ($urandom_range(100, 250)) cycle(noise(), 1'b0);
      cycle(noise(), 1'b1);
      if (rnd == 2) begin
        repeat (40) cycle(noise(), noise());
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
        rst = 1'b0;
      end else begin
        run_until_idle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reel_spinner.md
# reel_spinner

Parametrised multi-reel digit spinner for the win/lose game datapath. Drives NUM_REELS decimal-style digit counters that spin at individually staggered rates, accelerate after a start request, decelerate after a stop request, and halt one by one. Reports completion and whether all reels landed on the same digit. Sits between the button-debounce logic and the seven-segment display drivers.

## Interface
- NUM_REELS, 3, number of reels (1..8)
- DIGIT_W, 4, bits per reel digit
- MODULUS, 10, digit wraps MODULUS-1 -> 0 (2..2**DIGIT_W)
- PERIOD_W, 32, width of period and tick counters
- BASE_PERIOD, 250000, advance period of reel 0 at start (cycles)
- PERIOD_STEP, 50000, reel i base period = BASE_PERIOD - i*PERIOD_STEP
- RAMP_STEP, 1000, period change per digit advance during accel/decel
- MIN_PERIOD, 100000, acceleration floor (>= 2, <= smallest base period)
- MAX_PERIOD, 400000, deceleration ceiling (>= BASE_PERIOD)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin spinning
- stop  in  1  single-cycle request to begin decelerating
- digits  out  NUM_REELS*DIGIT_W  reel i digit at [i*DIGIT_W +: DIGIT_W]
- stopped  out  NUM_REELS  per-reel halted flag
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last reel halts
- win  out  1  all digits equal at last completion; held until next start

## Operation
- Reset values: digits 0, stopped all ones, busy 0, done 0, win 0, internal FSM IDLE, tick counters 0.
- Global FSM: IDLE -> SPIN on start; SPIN -> STOPPING on stop; STOPPING -> IDLE when all stopped bits set (done pulses on that transition).
- start in IDLE: each reel loads cur_period = its base period, tick = 0, clears its stopped bit; digits keep their values; win cleared.
- Each reel, while not halted: tick increments every cycle; when tick == cur_period-1: digit advances (wrap at MODULUS-1 -> 0), tick <= 0, period updated.
- SPIN period update: cur_period <= max(cur_period - RAMP_STEP, MIN_PERIOD).
- STOPPING period update: if cur_period + RAMP_STEP > MAX_PERIOD, the reel halts (this advance still occurs, stopped bit set, digit frozen); else cur_period <= cur_period + RAMP_STEP.
- Period arithmetic in PERIOD_W bits, saturating; no wrap on subtraction.
- Ignored: start while busy; stop in IDLE; stop while already STOPPING. start and stop in the same IDLE cycle: start accepted, stop dropped.
- win = all digits equal, registered on the done cycle.
- Reset mid-operation: immediate return to reset values; no done pulse.

## Timing
- start sampled at posedge; busy and cleared stopped visible the following cycle.
- First advance of reel i occurs base_period_i cycles after the start acceptance edge.
- stop takes effect on each reel's next advance (no immediate period change).
- done and win update on the cycle after the last reel's halting advance; busy falls in that same cycle.
- Single-reel configuration: done follows that reel's halt with the same one-cycle latency.

## Structure
- Package reel_pkg: FSM state enum (IDLE, SPIN, STOPPING), reel mode enum (HOLD, ACCEL, DECEL).
- Sub-module reel_unit: one reel (tick counter, period register, digit, halt flag); instantiated NUM_REELS times via generate, base period computed per index.
- Top: global FSM, start/stop qualification, done/win logic.

## Test plan
Bench parameters: NUM_REELS=3, MODULUS=10, BASE_PERIOD=20, PERIOD_STEP=4, RAMP_STEP=2, MIN_PERIOD=8, MAX_PERIOD=30.
- Reset -> digits 0, stopped 3'b111, busy 0, done 0, win 0.
- start pulse -> busy 1 next cycle; reel 2 first advance after 12 cycles, reel 1 after 16, reel 0 after 20; reel 2 periods 12,10,8,8.
- Spin long enough for wrap -> each digit 9 -> 0, no value 10..15 ever observed.
- stop pulse -> periods rise by 2 per advance; each reel halts on advance where period+2 > 30; exactly one done pulse, busy falls with it, win matches digit equality.
- start pulse during SPIN and STOPPING -> no change to periods, ticks or digits; stop in IDLE -> no effect.
- rst asserted mid-STOPPING -> outputs immediately at reset values, no done pulse; subsequent start behaves as from reset.
